// File: rtl/sap_run_arbiter.sv
// Run/halt/step sequencer and program-RAM port arbiter for the SAP CPU.
// The loader owns the RAM port in LOAD mode; the MAR owns it in every other state.
module sap_run_arbiter #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8,
    parameter logic [3:0]  HLT_OP = 4'b1111
) (
    input  logic              clock,
    input  logic              clr,
    input  logic              prog_mode,
    input  logic              run,
    input  logic              step,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [3:0]        ri,
    input  logic [2:0]        t_state,
    input  logic [ADDR_W-1:0] mar_addr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic              cpu_en,
    output logic              cpu_rst_n,
    output logic              halted,
    output logic [ADDR_W:0]   load_count
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_STEP = 3'd3;
    localparam logic [2:0] S_HALT = 3'd4;

    localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);

    logic [2:0]        state_q, state_d;
    logic              run_q, step_q;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              restart_q, restart_d;
    logic              stop_q, stop_d;

    logic run_rise, step_rise, accept, hlt_hit, ring_end;

    always_comb begin
        run_rise  = run & ~run_q;
        step_rise = step & ~step_q;
        accept    = (state_q == S_LOAD) & ~ram_we_q & ld_valid;
        hlt_hit   = (t_state == 3'd3) & (ri == HLT_OP);
        ring_end  = (t_state == 3'd5);

        state_d   = state_q;
        stop_d    = stop_q;
        count_d   = count_q;
        restart_d = 1'b0;
        ram_we_d  = accept;
        addr_d    = accept ? ld_addr : addr_q;
        wdata_d   = accept ? ld_data : wdata_q;

        case (state_q)
            S_IDLE: begin
                if (prog_mode) begin
                    state_d = S_LOAD;
                    count_d = '0;
                end else if (run_rise) begin
                    state_d = S_RUN;
                end else if (step_rise) begin
                    state_d = S_STEP;
                end
            end
            S_LOAD: begin
                if (ram_we_q) begin
                    if (count_q != CNT_MAX) begin
                        count_d = count_q + CNT_ONE;
                    end
                end else if (!ld_valid && !prog_mode) begin
                    // Leaving LOAD restarts the CPU so the new program runs from address 0.
                    state_d   = S_IDLE;
                    restart_d = 1'b1;
                end
            end
            S_RUN: begin
                if (hlt_hit) begin
                    state_d = S_HALT;
                    stop_d  = 1'b0;
                end else if (ring_end && (prog_mode || stop_q)) begin
                    state_d = S_IDLE;
                    stop_d  = 1'b0;
                end else if (prog_mode) begin
                    // Remember the stop request so a short prog_mode pulse still ends the run.
                    stop_d = 1'b1;
                end
            end
            S_STEP: begin
                if (hlt_hit) begin
                    state_d = S_HALT;
                end else if (ring_end) begin
                    state_d = S_IDLE;
                end
            end
            S_HALT: begin
                if (prog_mode) begin
                    state_d = S_LOAD;
                    count_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge clr) begin
        if (!clr) begin
            state_q   <= S_IDLE;
            run_q     <= 1'b0;
            step_q    <= 1'b0;
            ram_we_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            count_q   <= '0;
            restart_q <= 1'b0;
            stop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_q     <= run;
            step_q    <= step;
            ram_we_q  <= ram_we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            count_q   <= count_d;
            restart_q <= restart_d;
            stop_q    <= stop_d;
        end
    end

    always_comb begin
        ld_ready   = (state_q == S_LOAD) & ~ram_we_q;
        ram_we     = ram_we_q;
        ram_addr   = (state_q == S_LOAD) ? addr_q : mar_addr;
        ram_wdata  = wdata_q;
        cpu_en     = (state_q == S_RUN) | (state_q == S_STEP);
        cpu_rst_n  = ~restart_q;
        halted     = (state_q == S_HALT);
        load_count = count_q;
    end

endmodule

// File: tb/tb_sap_run_arbiter.sv
// Directed and randomized bench for sap_run_arbiter against a mode-flag reference model.
module tb_sap_run_arbiter;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam logic [3:0] HLT = 4'b1111;

    logic          clock = 1'b0;
    logic          clr = 1'b0;
    logic          prog_mode = 1'b0;
    logic          run = 1'b0;
    logic          step = 1'b0;
    logic          ld_valid = 1'b0;
    logic          ld_ready;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_data = '0;
    logic [3:0]    ri = '0;
    logic [2:0]    t_state = '0;
    logic [AW-1:0] mar_addr = '0;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_we;
    logic          cpu_en;
    logic          cpu_rst_n;
    logic          halted;
    logic [AW:0]   load_count;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    sap_run_arbiter #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .HLT_OP(HLT)
    ) dut (
        .clock(clock),
        .clr(clr),
        .prog_mode(prog_mode),
        .run(run),
        .step(step),
        .ld_valid(ld_valid),
        .ld_ready(ld_ready),
        .ld_addr(ld_addr),
        .ld_data(ld_data),
        .ri(ri),
        .t_state(t_state),
        .mar_addr(mar_addr),
        .ram_addr(ram_addr),
        .ram_wdata(ram_wdata),
        .ram_we(ram_we),
        .cpu_en(cpu_en),
        .cpu_rst_n(cpu_rst_n),
        .halted(halted),
        .load_count(load_count)
    );

    // Reference model: independent mode flags plus the environment's ring counter.
    bit            m_loading, m_running, m_stepping, m_halted;
    bit            m_wr, m_stop, m_restart, m_run_prev, m_step_prev;
    int            m_words;
    logic [AW-1:0] m_wa;
    logic [DW-1:0] m_wd;
    int            ring = 0;

    task automatic model_reset();
        m_loading = 0; m_running = 0; m_stepping = 0; m_halted = 0;
        m_wr = 0; m_stop = 0; m_restart = 0; m_run_prev = 0; m_step_prev = 0;
        m_words = 0; m_wa = '0; m_wd = '0;
    endtask

    task automatic model_step();
        bit rr, sr;
        rr = run && !m_run_prev;
        sr = step && !m_step_prev;
        m_run_prev = run;
        m_step_prev = step;
        m_restart = 0;
        if (m_loading) begin
            if (m_wr) begin
                m_wr = 0;
                if (m_words < 16) m_words++;
            end else if (ld_valid) begin
                m_wr = 1; m_wa = ld_addr; m_wd = ld_data;
            end else if (!prog_mode) begin
                m_loading = 0; m_restart = 1;
            end
        end else if (m_running || m_stepping) begin
            if (t_state == 3'd3 && ri == HLT) begin
                m_running = 0; m_stepping = 0; m_halted = 1; m_stop = 0;
            end else if (t_state == 3'd5 && (m_stepping || prog_mode || m_stop)) begin
                m_running = 0; m_stepping = 0; m_stop = 0;
            end else if (m_running && prog_mode) begin
                m_stop = 1;
            end
        end else if (m_halted) begin
            if (prog_mode) begin
                m_halted = 0; m_loading = 1; m_words = 0;
            end
        end else begin
            if (prog_mode) begin
                m_loading = 1; m_words = 0;
            end else if (rr) begin
                m_running = 1;
            end else if (sr) begin
                m_stepping = 1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("ld_ready", 16'(ld_ready), 16'(m_loading && !m_wr));
        chk("ram_we", 16'(ram_we), 16'(m_wr));
        chk("ram_addr", 16'(ram_addr), 16'(m_loading ? m_wa : mar_addr));
        chk("ram_wdata", 16'(ram_wdata), 16'(m_wd));
        chk("cpu_en", 16'(cpu_en), 16'(m_running || m_stepping));
        chk("cpu_rst_n", 16'(cpu_rst_n), 16'(!m_restart));
        chk("halted", 16'(halted), 16'(m_halted));
        chk("load_count", 16'(load_count), 16'(m_words));
    endtask

    task automatic tick();
        bit en;
        @(posedge clock);
        #1;
        en = m_running || m_stepping;
        model_step();
        if (en) ring = (ring + 1) % 6;
        if (m_restart) ring = 0;
        t_state = 3'(ring);
        #1;
        check_all();
    endtask

    task automatic load_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit took;
        ld_addr = a;
        ld_data = d;
        ld_valid = 1'b1;
        took = 0;
        for (int i = 0; i < 8 && !took; i++) begin
            took = m_loading && !m_wr;
            tick();
        end
        chk("load_accept", 16'(took), 16'd1);
    endtask

    initial begin
        int en_cnt;
        bit seen_t5;

        model_reset();
        #23;
        check_all();
        clr = 1'b1;
        tick();
        tick();

        // Three held-valid words: write pulses two cycles apart.
        prog_mode = 1'b1;
        tick();
        load_word(4'd0, 8'h09);
        load_word(4'd1, 8'h1A);
        load_word(4'd2, 8'hE0);
        ld_valid = 1'b0;
        tick();
        chk("t1_count", 16'(load_count), 16'd3);

        // Fresh session of 20 words saturates the count, then restart pulse on exit.
        prog_mode = 1'b0;
        tick();
        prog_mode = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) load_word(AW'(i), DW'($urandom));
        ld_valid = 1'b0;
        tick();
        chk("t2_count_sat", 16'(load_count), 16'd16);
        prog_mode = 1'b0;
        tick();
        chk("t2_rst_low", 16'(cpu_rst_n), 16'd0);
        tick();
        chk("t2_rst_high", 16'(cpu_rst_n), 16'd1);

        // Free run, HLT fetched in the second instruction.
        ri = 4'h0;
        run = 1'b1;
        tick();
        seen_t5 = 0;
        for (int i = 0; i < 40 && !m_halted; i++) begin
            if (ring == 5) seen_t5 = 1;
            ri = (seen_t5 && ring == 3) ? HLT : 4'h0;
            tick();
        end
        ri = 4'h0;
        chk("t3_halted", 16'(halted), 16'd1);
        chk("t3_en_off", 16'(cpu_en), 16'd0);
        run = 1'b0;
        tick();
        run = 1'b1;
        tick();
        tick();
        chk("t3_run_ignored", 16'(halted), 16'd1);

        // Leave HALT through LOAD, then single step.
        prog_mode = 1'b1;
        tick();
        tick();
        prog_mode = 1'b0;
        tick();
        tick();
        step = 1'b1;
        tick();
        en_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (cpu_en) en_cnt++;
            tick();
        end
        step = 1'b0;
        chk("t4_en_cycles", 16'(en_cnt), 16'd6);
        chk("t4_idle", 16'({cpu_en, ld_ready, halted}), 16'd0);

        // prog_mode during RUN at t3: instruction completes, then IDLE, then LOAD.
        run = 1'b0;
        tick();
        run = 1'b1;
        tick();
        en_cnt = 0;
        for (int i = 0; i < 40 && !m_loading; i++) begin
            if (ring == 2) prog_mode = 1'b1;
            if (cpu_en) en_cnt++;
            tick();
        end
        chk("t5_en_cycles", 16'(en_cnt), 16'd6);
        chk("t5_in_load", 16'(ld_ready), 16'd1);

        // Asynchronous clear in the middle of a write cycle.
        load_word(4'd4, 8'hA5);
        load_word(4'd5, 8'h5A);
        chk("t6_we_before", 16'(ram_we), 16'd1);
        #3;
        clr = 1'b0;
        model_reset();
        #1;
        chk("t6_we", 16'(ram_we), 16'd0);
        chk("t6_ready", 16'(ld_ready), 16'd0);
        chk("t6_en", 16'(cpu_en), 16'd0);
        chk("t6_count", 16'(load_count), 16'd0);
        check_all();
        ld_valid = 1'b0;
        prog_mode = 1'b0;
        run = 1'b0;
        #2;
        clr = 1'b1;
        tick();

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) prog_mode = ~prog_mode;
            if ($urandom_range(0, 7) == 0) run = ~run;
            if ($urandom_range(0, 7) == 0) step = ~step;
            ld_valid = 1'($urandom_range(0, 1));
            ld_addr = AW'($urandom);
            ld_data = DW'($urandom);
            mar_addr = AW'($urandom);
            if (ring == 0) ri = ($urandom_range(0, 5) == 0) ? HLT : 4'($urandom_range(0, 14));
            tick();
            if (i == 200) begin
                #3;
                clr = 1'b0;
                model_reset();
                #1;
                check_all();
                #1;
                clr = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
